// File: rtl/oled_display_arbiter_if.sv
// Requester and OLED-driver signals of the display arbiter.
// master: the arbiter; slave: the requesters plus the text driver.
interface oled_display_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    localparam int unsigned OwnerW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]     req;
    logic [NREQ*512-1:0] text_in;
    logic [NREQ-1:0]     ack;
    logic [511:0]        oled_text;
    logic                oled_update;
    logic                oled_busy;
    logic [OwnerW-1:0]   owner;
    logic                owner_valid;
    logic                err;

    modport master (
        input  req, text_in, oled_busy,
        output ack, oled_text, oled_update, owner, owner_valid, err
    );

    modport slave (
        output req, text_in, oled_busy,
        input  ack, oled_text, oled_update, owner, owner_valid, err
    );
endinterface

// File: rtl/oled_display_arbiter.sv
// Priority arbiter owning the single OLED text driver: latches the winning frame, runs the
// valid/busy handshake, then holds the frame for a minimum time that only equal/higher sources cut.
module oled_display_arbiter #(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned TIMEOUT     = 1_000_000
) (
    input logic                   clk,
    input logic                   reset_n,
    oled_display_arbiter_if.master bus
);
    localparam int unsigned OwnerW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HoldLoad    = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StDraw, StHold} state_e;

    state_e             state_q, state_d;
    logic [511:0]       text_q, text_d;
    logic               update_q, update_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [OwnerW-1:0]  owner_q, owner_d;
    logic               owner_valid_q, owner_valid_d;
    logic               err_q, err_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;

    logic [NREQ-1:0]    elig;
    logic [OwnerW-1:0]  pick;
    logic [511:0]       pick_text;
    logic [TW-1:0]      tcnt_inc;
    logic               load;
    logic               finish;

    // A source is blind for the cycle its ack is high, so a late req drop is not re-served.
    always_comb begin
        elig      = bus.req & ~ack_q;
        pick      = '0;
        pick_text = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick      = OwnerW'(i);
                pick_text = bus.text_in[i*512 +: 512];
            end
        end
    end

    assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        text_d        = text_q;
        update_d      = update_q;
        ack_d         = '0;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        err_d         = err_q;
        tcnt_d        = tcnt_q;
        hcnt_d        = hcnt_q;
        load          = 1'b0;
        finish        = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = |elig;
            end
            StSend: begin
                tcnt_d = tcnt_inc;
                if (bus.oled_busy) begin
                    update_d = 1'b0;
                    tcnt_d   = '0;
                    state_d  = StDraw;
                end else if (tcnt_q == TimeoutLast) begin
                    update_d = 1'b0;
                    err_d    = 1'b1;
                    finish   = 1'b1;
                end
            end
            StDraw: begin
                tcnt_d = tcnt_inc;
                if (!bus.oled_busy) begin
                    finish = 1'b1;
                end else if (tcnt_q == TimeoutLast) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end
            end
            StHold: begin
                // The lowest eligible index is <= owner whenever any preempting source exists.
                if ((|elig) && (pick <= owner_q)) begin
                    load = 1'b1;
                end else if (hcnt_q == '0) begin
                    owner_valid_d = 1'b0;
                    state_d       = StIdle;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            text_d   = pick_text;
            owner_d  = pick;
            update_d = 1'b1;
            tcnt_d   = '0;
            state_d  = StSend;
        end
        if (finish) begin
            ack_d[owner_q] = 1'b1;
            hcnt_d         = HoldLoad;
            owner_valid_d  = 1'b1;
            state_d        = StHold;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            text_q        <= {64{8'd32}};
            update_q      <= 1'b0;
            ack_q         <= '0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            err_q         <= 1'b0;
            tcnt_q        <= '0;
            hcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            text_q        <= text_d;
            update_q      <= update_d;
            ack_q         <= ack_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            err_q         <= err_d;
            tcnt_q        <= tcnt_d;
            hcnt_q        <= hcnt_d;
        end
    end

    assign bus.oled_text   = text_q;
    assign bus.oled_update = update_q;
    assign bus.ack         = ack_q;
    assign bus.owner       = owner_q;
    assign bus.owner_valid = owner_valid_q;
    assign bus.err         = err_q;
endmodule
